// File: rtl/next_kb_pkg.sv
// next_kb_pkg: command constants, frame sizes, response field offsets and FSM states for the NeXT keyboard endpoint
package next_kb_pkg;
    localparam int HOST_BITS = 9;
    localparam int RESP_BITS = 21;
    localparam int TX_BITS = RESP_BITS + 2;
    localparam logic [HOST_BITS-1:0] CMD_QUERY = 9'h010;
    localparam logic [1:0] CMD_LED_PREFIX = 2'b11;
    localparam int RESP_CODE_LSB = 0;
    localparam int RESP_UP_BIT = 7;
    localparam int RESP_MODS_LSB = 8;
    localparam int RESP_VALID_BIT = 16;
    typedef enum logic [2:0] {ST_IDLE, ST_RX_START, ST_RX_DATA, ST_RX_STOP, ST_TURN, ST_TX} state_e;
    function automatic logic [RESP_BITS-1:0] resp_word(input logic vld, input logic [15:0] ev);
        logic [RESP_BITS-1:0] r;
        r = '0;
        r[RESP_CODE_LSB +: 7] = ev[6:0];
        r[RESP_UP_BIT] = ev[7];
        r[RESP_MODS_LSB +: 8] = ev[15:8];
        r[RESP_VALID_BIT] = 1'b1;
        return vld ? r : '0;
    endfunction
endpackage

// File: rtl/next_kb_if.sv
// next_kb_if: key-event valid/ready handshake from a scanner (master) into the keyboard endpoint (slave)
interface next_kb_if;
    logic [6:0] code;
    logic       up;
    logic [7:0] mods;
    logic       valid;
    logic       ready;
    modport master(output code, up, mods, valid, input ready);
    modport slave(input code, up, mods, valid, output ready);
endinterface

// File: rtl/next_kb_event_fifo.sv
// next_kb_event_fifo: synchronous FIFO with valid/ready on both sides and an occupancy count
module next_kb_event_fifo #(
    parameter int W = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   hw_reset_n,
    input  logic [W-1:0]           in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [W-1:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] count_q, count_d;
    logic push, pop;
    // ready is forced low while reset is held so nothing is accepted mid-reset
    always_comb begin
        in_ready = hw_reset_n && count_q != (AW+1)'(DEPTH);
        out_valid = count_q != '0;
        out_data = mem_q[rd_q];
        push = in_valid && in_ready;
        pop = out_ready && out_valid;
        wr_d = push ? wr_q + 1'b1 : wr_q;
        rd_d = pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clk) begin
        if (!hw_reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk)
        if (push) mem_q[wr_q] <= in_data;
    assign count = count_q;
endmodule

// File: rtl/next_kb_device.sv
// next_kb_device: NeXT keyboard-side serial endpoint; define NEXT_KB_LED_EN to decode LED_SET frames
module next_kb_device
    import next_kb_pkg::*;
#(
    parameter int BIT_CLKS = 1424,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        hw_reset_n,
    input  logic                        to_kb,
    output logic                        from_kb,
    next_kb_if.slave                    key,
    output logic [1:0]                  leds,
    output logic                        cmd_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
`ifdef NEXT_KB_LED_EN
    localparam bit LED_EN = 1'b1;
`else
    localparam bit LED_EN = 1'b0;
`endif
    localparam int CW = $clog2(2 * BIT_CLKS);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, last;
    logic [4:0] bit_q, bit_d;
    logic [HOST_BITS-1:0] rx_q, rx_d;
    logic [TX_BITS-1:0] tx_q, tx_d;
    logic [1:0] leds_q, leds_d;
    logic err_q, err_d;
    logic sync1_q, sync_q, prev_q;
    logic tick, fall, stop, is_query, is_led, enter_tx, ev_valid, pop;
    logic [15:0] ev_data;
    next_kb_event_fifo #(.W(16), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .hw_reset_n(hw_reset_n),
        .in_data({key.mods, key.up, key.code}), .in_valid(key.valid), .in_ready(key.ready),
        .out_data(ev_data), .out_valid(ev_valid), .out_ready(pop), .count(fifo_count)
    );
    always_ff @(posedge clk) begin
        if (!hw_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            rx_q <= '0;
            tx_q <= '1;
            leds_q <= '0;
            err_q <= 1'b0;
            sync1_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            rx_q <= rx_d;
            tx_q <= tx_d;
            leds_q <= leds_d;
            err_q <= err_d;
            sync1_q <= to_kb;
            sync_q <= sync1_q;
            prev_q <= sync_q;
        end
    end
    always_comb begin
        last = state_q == ST_RX_START ? CW'(BIT_CLKS / 2 - 1) :
               state_q == ST_TURN ? CW'(2 * BIT_CLKS - 1) : CW'(BIT_CLKS - 1);
        tick = cnt_q == last;
        fall = prev_q && !sync_q;
        is_query = rx_q == CMD_QUERY;
        is_led = LED_EN && rx_q[HOST_BITS-1 -: 2] == CMD_LED_PREFIX;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (fall) state_d = ST_RX_START;
            ST_RX_START: if (tick) state_d = sync_q ? ST_IDLE : ST_RX_DATA;
            ST_RX_DATA:  if (tick && bit_q == 5'(HOST_BITS - 1)) state_d = ST_RX_STOP;
            ST_RX_STOP:  if (tick) state_d = (sync_q && is_query) ? ST_TURN : ST_IDLE;
            ST_TURN:     if (tick) state_d = ST_TX;
            ST_TX:       if (tick && bit_q == 5'(TX_BITS - 1)) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end
    // from_kb is the LSB of a shift register that refills with ones, so idle and reset drive high
    always_comb begin
        stop = state_q == ST_RX_STOP && tick;
        enter_tx = state_q == ST_TURN && tick;
        pop = enter_tx && ev_valid;
        cnt_d = (tick || state_q == ST_IDLE) ? '0 : cnt_q + 1'b1;
        bit_d = (state_q == ST_RX_DATA || state_q == ST_TX) ? (tick ? bit_q + 1'b1 : bit_q) : '0;
        rx_d = (state_q == ST_RX_DATA && tick) ? {sync_q, rx_q[HOST_BITS-1:1]} : rx_q;
        tx_d = enter_tx ? {1'b1, resp_word(ev_valid, ev_data), 1'b0} :
               (state_q == ST_TX && tick) ? {1'b1, tx_q[TX_BITS-1:1]} : tx_q;
        leds_d = (stop && sync_q && is_led) ? rx_q[1:0] : leds_q;
        err_d = stop && !(sync_q && (is_query || is_led));
    end
    assign from_kb = tx_q[0];
    assign leds = leds_q;
    assign cmd_err = err_q;
endmodule

// File: tb/tb_next_kb_device.sv
// tb_next_kb_device: directed self-checking bench for next_kb_device at BIT_CLKS=16
module tb_next_kb_device;
    localparam int B = 16;
    logic clk = 1'b0;
    logic hw_reset_n = 1'b0;
    logic to_kb = 1'b1;
    logic from_kb, cmd_err;
    logic [1:0] leds;
    logic [3:0] fifo_count;
    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    next_kb_if kif();
    next_kb_device #(.BIT_CLKS(B), .FIFO_DEPTH(8)) dut (
        .clk(clk), .hw_reset_n(hw_reset_n), .to_kb(to_kb), .from_kb(from_kb),
        .key(kif), .leds(leds), .cmd_err(cmd_err), .fifo_count(fifo_count)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (cmd_err) err_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [8:0] data, input logic stop_bit);
        logic [10:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int j = 0; j < 11; j++) begin
            to_kb = bits[j];
            tick(B);
        end
        to_kb = 1'b1;
    endtask

    task automatic wait_fall(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick(1);
            if (!from_kb) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic rx_resp(output logic [22:0] f);
        for (int j = 0; j < 23; j++) begin
            tick(j == 0 ? B / 2 : B);
            f[j] = from_kb;
        end
    endtask

    task automatic query(input string tag, input logic [20:0] exp);
        int n;
        logic [22:0] f;
        send_frame(9'h010, 1'b1);
        wait_fall(60, n);
        check({tag, " latency"}, n, 27);
        if (n > 0) begin
            rx_resp(f);
            check({tag, " frame"}, f, {1'b1, exp, 1'b0});
        end
        tick(B);
    endtask

    task automatic push(input logic [6:0] code, input logic up, input logic [7:0] mods);
        int w;
        kif.code = code;
        kif.up = up;
        kif.mods = mods;
        kif.valid = 1'b1;
        w = 0;
        while (!kif.ready && w < 100) begin
            tick(1);
            w++;
        end
        check("push ready", kif.ready, 1);
        tick(1);
        kif.valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, e0;
        logic [22:0] f;
        kif.valid = 1'b0;
        kif.code = '0;
        kif.up = 1'b0;
        kif.mods = '0;
        tick(3);
        check("rst key_ready", kif.ready, 0);
        check("rst from_kb", from_kb, 1);
        hw_reset_n = 1'b1;
        #1;
        check("release key_ready", kif.ready, 1);
        check("rst leds", leds, 0);
        check("rst cmd_err", cmd_err, 0);
        check("rst count", fifo_count, 0);
        tick(4);
        query("q empty", 21'h0);
        check("count empty", fifo_count, 0);
        push(7'h2A, 1'b0, 8'h04);
        check("count one", fifo_count, 1);
        query("q event", 21'h01042A);
        check("count drained", fifo_count, 0);
        query("q after drain", 21'h0);
        for (int i = 0; i < 8; i++) push(7'h10 + 7'(i), i[0], 8'(i));
        check("count full", fifo_count, 8);
        check("full ready", kif.ready, 0);
        kif.code = 7'h18;
        kif.up = 1'b0;
        kif.mods = 8'h08;
        kif.valid = 1'b1;
        tick(2);
        check("ninth held", fifo_count, 8);
        send_frame(9'h010, 1'b1);
        wait_fall(60, n);
        check("q full latency", n, 27);
        if (n > 0) begin
            check("ready after pop", kif.ready, 1);
            check("count after pop", fifo_count, 7);
            fork
                rx_resp(f);
                begin
                    tick(1);
                    kif.valid = 1'b0;
                end
            join
            check("q full frame", f, {1'b1, 21'h010010, 1'b0});
            check("ninth accepted", fifo_count, 8);
        end
        tick(B);
        query("q order", 21'h010191);
        check("count order", fifo_count, 7);
        e0 = err_pulses;
        send_frame(9'h181, 1'b1);
        tick(2);
`ifdef NEXT_KB_LED_EN
        check("leds 01", leds, 2'b01);
`else
        check("leds off 181", leds, 2'b00);
`endif
        send_frame(9'h182, 1'b1);
        tick(2);
`ifdef NEXT_KB_LED_EN
        check("leds 10", leds, 2'b10);
        check("led no err", err_pulses - e0, 0);
`else
        check("leds off 182", leds, 2'b00);
        check("led unknown err", err_pulses - e0, 2);
`endif
        wait_fall(60, n);
        check("led no tx", n, -1);
        e0 = err_pulses;
        send_frame(9'h010, 1'b0);
        tick(2);
        check("framing err pulse", err_pulses - e0, 1);
        wait_fall(60, n);
        check("framing no tx", n, -1);
        e0 = err_pulses;
        to_kb = 1'b0;
        tick(4);
        to_kb = 1'b1;
        tick(30);
        check("glitch no err", err_pulses - e0, 0);
        query("q after glitch", 21'h010212);
        check("count after glitch", fifo_count, 6);
        send_frame(9'h010, 1'b1);
        wait_fall(60, n);
        check("q reset latency", n, 27);
        if (n > 0) begin
            tick(B / 2 + 10 * B);
            hw_reset_n = 1'b0;
            tick(1);
            check("midtx from_kb", from_kb, 1);
            check("midtx count", fifo_count, 0);
            check("midtx key_ready", kif.ready, 0);
            tick(1);
            hw_reset_n = 1'b1;
            #1;
            check("midtx release ready", kif.ready, 1);
        end
        tick(4);
        query("q after reset", 21'h0);
        check("count after reset", fifo_count, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
